// File: rtl/collatz_sweep_ctrl.sv
// Sweep sequencer around the Collatz iteration core: launches one run per N in
// [n_first, n_last], collects each iteration count and tracks the longest run.
module collatz_sweep_ctrl #(
    parameter int W       = 8,
    parameter int TIMEOUT = 1000,
    parameter int TW      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] n_first,
    input  logic [W-1:0] n_last,
    output logic [W-1:0] core_n,
    output logic         core_start,
    input  logic         core_busy,
    input  logic [W-1:0] core_count,
    output logic [W-1:0] cur_n,
    output logic [W-1:0] max_count,
    output logic [W-1:0] max_n,
    output logic         busy,
    output logic         done,
    output logic [1:0]   err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    // Last permitted wait cycle: the timer reaches TIMEOUT as this cycle ends.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [W-1:0]  last_q;
    logic [TW-1:0] timer;
    logic          go_ok;
    logic          range_bad;
    logic          in_wait;
    logic          timed_out;
    logic          at_last;

    assign go_ok     = go && ((state == S_IDLE) || (state == S_DONE));
    assign range_bad = (n_first == '0) || (n_first > n_last);
    assign in_wait   = (state == S_WAIT_HI) || (state == S_WAIT_LO);
    assign timed_out = in_wait && (timer == TMO_LAST);
    // Equality only, so a sweep ending at the all-ones N never wraps.
    assign at_last   = (cur_n == last_q);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (go_ok) state_nx = range_bad ? S_DONE : S_LAUNCH;
            end
            S_LAUNCH:  state_nx = S_WAIT_HI;
            S_WAIT_HI: begin
                if (timed_out)      state_nx = S_DONE;
                else if (core_busy) state_nx = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (timed_out)       state_nx = S_DONE;
                else if (!core_busy) state_nx = S_CAPTURE;
            end
            S_CAPTURE: state_nx = S_NEXT;
            S_NEXT:    state_nx = at_last ? S_DONE : S_LAUNCH;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Status outputs are registered copies of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            core_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            core_start <= (state_nx == S_LAUNCH);
            busy       <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done       <= (state_nx == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= '0;
            cur_n     <= '0;
            core_n    <= '0;
            max_count <= '0;
            max_n     <= '0;
            err       <= ERR_OK;
            timer     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go_ok) begin
                        max_count <= '0;
                        max_n     <= '0;
                        if (range_bad) begin
                            err <= ERR_RANGE;
                        end else begin
                            err    <= ERR_OK;
                            last_q <= n_last;
                            cur_n  <= n_first;
                            core_n <= n_first;
                        end
                    end
                end
                S_LAUNCH: timer <= '0;
                S_WAIT_HI, S_WAIT_LO: begin
                    timer <= timer + TW'(1);
                    if (timed_out) err <= ERR_TMO;
                end
                S_CAPTURE: begin
                    // Strict compare keeps the smaller N on ties.
                    if (core_count > max_count) begin
                        max_count <= core_count;
                        max_n     <= cur_n;
                    end
                end
                S_NEXT: begin
                    if (!at_last) begin
                        cur_n  <= cur_n + W'(1);
                        core_n <= cur_n + W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Bench for collatz_sweep_ctrl: behavioural Collatz core model with random
// busy-rise delays, plus a plain-arithmetic reference for sweep results.
module tb_collatz_sweep_ctrl;

    localparam int W       = 8;
    localparam int TIMEOUT = 1000;
    localparam int TW      = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         go = 1'b0;
    logic [W-1:0] n_first = '0;
    logic [W-1:0] n_last = '0;
    logic [W-1:0] core_n;
    logic         core_start;
    logic         core_busy = 1'b0;
    logic [W-1:0] core_count = '0;
    logic [W-1:0] cur_n;
    logic [W-1:0] max_count;
    logic [W-1:0] max_n;
    logic         busy;
    logic         done;
    logic [1:0]   err;

    collatz_sweep_ctrl #(.W(W), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .n_first(n_first), .n_last(n_last),
        .core_n(core_n), .core_start(core_start), .core_busy(core_busy),
        .core_count(core_count), .cur_n(cur_n), .max_count(max_count),
        .max_n(max_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int hang_n = -1;
    bit tie_mode = 1'b0;
    bit release_core = 1'b0;
    int launches[$];
    int m_n, m_d, m_cnt;

    function automatic int collatz(input int n);
        int v = n;
        int s = 0;
        while (v > 1) begin
            v = (v % 2 != 0) ? 3 * v + 1 : v / 2;
            s++;
        end
        return s;
    endfunction

    function automatic int model_count(input int n);
        return tie_mode ? 5 : collatz(n);
    endfunction

    // Core model: busy rises 0..3 cycles after the launch and lasts count+2 cycles.
    always begin
        @(posedge clk);
        if (core_start === 1'b1 && rst_n === 1'b1) begin
            m_n   = int'(core_n);
            m_d   = int'($urandom_range(3, 0));
            m_cnt = model_count(m_n);
            launches.push_back(m_n);
            for (int k = 0; k < m_d; k++) @(posedge clk);
            #1;
            core_busy  = 1'b1;
            core_count = 8'hEE;
            if (m_n == hang_n) begin
                while (rst_n === 1'b1 && !release_core) @(posedge clk);
            end else begin
                for (int k = 0; k < m_cnt + 2 && rst_n === 1'b1; k++) @(posedge clk);
            end
            #1;
            core_count = W'(m_cnt);
            core_busy  = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ref_max(input int f, input int l, output int mc, output int mn);
        mc = 0;
        mn = 0;
        for (int n = f; n <= l; n++) begin
            if (model_count(n) > mc) begin
                mc = model_count(n);
                mn = n;
            end
        end
    endtask

    task automatic start_sweep(input int f, input int l);
        @(negedge clk);
        n_first = W'(f);
        n_last  = W'(l);
        go      = 1'b1;
        @(negedge clk);
        go      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic run_sweep(input int f, input int l, input int exp_max, input int exp_n);
        int bad = 0;
        launches.delete();
        start_sweep(f, l);
        wait_done("sweep_done", (l - f + 1) * 150 + 20);
        check("launch_cnt", launches.size(), l - f + 1);
        foreach (launches[i]) if (launches[i] != f + i) bad++;
        check("launch_order", bad, 0);
        check("max_count", 32'(max_count), exp_max);
        check("max_n", 32'(max_n), exp_n);
        check("err_ok", 32'(err), 0);
        check("cur_n_end", 32'(cur_n), l);
        check("busy_low", 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int mc, mn, f, l, k, t;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_data", {cur_n, max_count, max_n, core_n}, 0);
        check("rst_ctl", {27'd0, core_start, busy, done, err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_done", 32'(done), 0);

        // Full 1..10 sweep with true Collatz counts
        run_sweep(1, 10, 19, 9);

        // Ties keep the smallest N
        tie_mode = 1'b1;
        run_sweep(4, 7, 5, 4);
        tie_mode = 1'b0;

        // Range errors: first > last, then first == 0
        for (int r = 0; r < 2; r++) begin
            launches.delete();
            start_sweep(r == 0 ? 5 : 0, 3);
            check("range_done", 32'(done), 1);
            check("range_err", 32'(err), 1);
            check("range_max", {max_count, max_n}, 0);
            repeat (3) @(negedge clk);
            check("range_no_launch", launches.size(), 0);
        end

        // Timeout: N=6 never drops busy
        hang_n = 6;
        launches.delete();
        start_sweep(5, 8);
        k = 0;
        while (!(core_start === 1'b1 && core_n == W'(6)) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("tmo_launch6", 32'(core_n), 6);
        t = 0;
        while (err !== 2'b10 && t < TIMEOUT + 50) begin
            @(negedge clk);
            t++;
        end
        // LAUNCH cycle followed by TIMEOUT wait cycles, then the registered abort.
        check("tmo_latency", t, TIMEOUT + 1);
        check("tmo_done", 32'(done), 1);
        check("tmo_cur_n", 32'(cur_n), 6);
        check("tmo_max_n", 32'(max_n), 5);
        check("tmo_max_count", 32'(max_count), collatz(5));
        repeat (5) @(negedge clk);
        check("tmo_no_launch7", launches.size(), 2);
        release_core = 1'b1;
        repeat (4) @(negedge clk);
        release_core = 1'b0;
        hang_n = -1;

        // Single-N sweep at the top of the range
        ref_max(255, 255, mc, mn);
        run_sweep(255, 255, mc, mn);
        repeat (6) @(negedge clk);
        check("top_no_wrap", launches.size(), 1);
        check("top_hold_done", 32'(done), 1);

        // go during WAIT_LO is ignored
        launches.delete();
        start_sweep(3, 5);
        k = 0;
        while (!(launches.size() >= 1 && core_busy === 1'b1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_first = 8'd200;
        n_last  = 8'd201;
        go      = 1'b1;
        @(negedge clk);
        go      = 1'b0;
        wait_done("ign_done", 800);
        check("ign_launches", launches.size(), 3);
        check("ign_max_count", 32'(max_count), collatz(3));
        check("ign_max_n", 32'(max_n), 3);
        check("ign_cur_n", 32'(cur_n), 5);

        // Random sweeps against the reference
        for (int r = 0; r < 4; r++) begin
            f = int'($urandom_range(240, 1));
            l = f + int'($urandom_range(5, 0));
            ref_max(f, l, mc, mn);
            run_sweep(f, l, mc, mn);
        end

        // Asynchronous reset in WAIT_LO of N=3
        launches.delete();
        start_sweep(1, 4);
        k = 0;
        while (!(launches.size() >= 3 && core_busy === 1'b1) && k < 500) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", {cur_n, max_count, max_n, core_n}, 0);
        check("arst_ctl", {27'd0, core_start, busy, done, err}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_idle", {30'd0, busy, done}, 0);
        run_sweep(1, 4, 7, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
